// File: rtl/cpu_program_loader_pkg.sv
// Shared encodings for the program loader: command codes, header field
// positions and FSM states.
package cpu_program_loader_pkg;

  typedef enum logic [1:0] {
    CMD_LOAD_I = 2'b00,
    CMD_LOAD_D = 2'b01,
    CMD_RUN    = 2'b10,
    CMD_HALT   = 2'b11
  } cmd_e;

  localparam int CMD_MSB   = 31;
  localparam int CMD_LSB   = 30;
  localparam int START_MSB = 29;
  localparam int START_LSB = 16;
  localparam int COUNT_MSB = 15;
  localparam int COUNT_LSB = 0;

  typedef enum logic [2:0] {
    ST_HDR       = 3'd0,
    ST_LOAD_I    = 3'd1,
    ST_LOAD_D_LO = 3'd2,
    ST_LOAD_D_HI = 3'd3,
    ST_DRAIN     = 3'd4,
    ST_RUN       = 3'd5
  } state_e;

endpackage

// File: rtl/cpu_program_loader.sv
// Command-stream loader: decodes headers, writes imem words / dmem dwords,
// and gates cpu enable between RUN and HALT.
module cpu_program_loader
  import cpu_program_loader_pkg::*;
#(
  parameter int IMEM_WORDS = 128,
  parameter int DMEM_WORDS = 128
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        s_valid,
  input  logic [31:0] s_data,
  output logic        s_ready,
  output logic        cpu_enable,
  output logic [63:0] addr_ext,
  output logic        wen_ext,
  output logic        ren_ext,
  output logic [31:0] wdata_ext,
  output logic [63:0] addr_ext_2,
  output logic        wen_ext_2,
  output logic        ren_ext_2,
  output logic [63:0] wdata_ext_2,
  output logic        busy,
  output logic        err
);

  localparam logic [16:0] IMEM_LIM = 17'(IMEM_WORDS);
  localparam logic [16:0] DMEM_LIM = 17'(DMEM_WORDS);

  state_e      state, state_next;
  logic [13:0] idx, idx_next;
  logic [16:0] rem, rem_next;
  logic [31:0] lo_word;
  logic        wr_i, wr_d, latch_lo, err_set;

  cmd_e        hdr_cmd;
  logic [13:0] hdr_start;
  logic [15:0] hdr_count;
  logic [16:0] hdr_end;

  assign s_ready   = 1'b1;
  assign ren_ext   = 1'b0;
  assign ren_ext_2 = 1'b0;
  assign busy      = (state != ST_HDR) && (state != ST_RUN);

  always_comb begin
    hdr_cmd   = cmd_e'(s_data[CMD_MSB:CMD_LSB]);
    hdr_start = s_data[START_MSB:START_LSB];
    hdr_count = s_data[COUNT_MSB:COUNT_LSB];
    // 17-bit sum so a large start + count cannot wrap past the depth check
    hdr_end   = {3'b000, hdr_start} + {1'b0, hdr_count};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_HDR;
      idx   <= '0;
      rem   <= '0;
    end else begin
      state <= state_next;
      idx   <= idx_next;
      rem   <= rem_next;
    end
  end

  always_comb begin
    state_next = state;
    idx_next   = idx;
    rem_next   = rem;
    wr_i       = 1'b0;
    wr_d       = 1'b0;
    latch_lo   = 1'b0;
    err_set    = 1'b0;
    if (s_valid) begin
      case (state)
        ST_HDR: begin
          case (hdr_cmd)
            CMD_LOAD_I: begin
              if (hdr_count != 16'd0) begin
                rem_next = {1'b0, hdr_count};
                if (hdr_end > IMEM_LIM) begin
                  err_set    = 1'b1;
                  state_next = ST_DRAIN;
                end else begin
                  idx_next   = hdr_start;
                  state_next = ST_LOAD_I;
                end
              end
            end
            CMD_LOAD_D: begin
              if (hdr_count != 16'd0) begin
                if (hdr_end > DMEM_LIM) begin
                  // a rejected dword load still carries two payload words per dword
                  err_set    = 1'b1;
                  rem_next   = {hdr_count, 1'b0};
                  state_next = ST_DRAIN;
                end else begin
                  idx_next   = hdr_start;
                  rem_next   = {1'b0, hdr_count};
                  state_next = ST_LOAD_D_LO;
                end
              end
            end
            CMD_RUN:  state_next = ST_RUN;
            CMD_HALT: state_next = ST_HDR;
          endcase
        end
        ST_LOAD_I: begin
          wr_i     = 1'b1;
          idx_next = idx + 14'd1;
          rem_next = rem - 17'd1;
          if (rem == 17'd1) state_next = ST_HDR;
        end
        ST_LOAD_D_LO: begin
          latch_lo   = 1'b1;
          state_next = ST_LOAD_D_HI;
        end
        ST_LOAD_D_HI: begin
          wr_d       = 1'b1;
          idx_next   = idx + 14'd1;
          rem_next   = rem - 17'd1;
          state_next = (rem == 17'd1) ? ST_HDR : ST_LOAD_D_LO;
        end
        ST_DRAIN: begin
          rem_next = rem - 17'd1;
          if (rem == 17'd1) state_next = ST_HDR;
        end
        ST_RUN: begin
          if (hdr_cmd == CMD_HALT) state_next = ST_HDR;
          else                     err_set    = 1'b1;
        end
        default: state_next = ST_HDR;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wen_ext     <= 1'b0;
      wen_ext_2   <= 1'b0;
      addr_ext    <= '0;
      wdata_ext   <= '0;
      addr_ext_2  <= '0;
      wdata_ext_2 <= '0;
      lo_word     <= '0;
      cpu_enable  <= 1'b0;
      err         <= 1'b0;
    end else begin
      wen_ext    <= wr_i;
      wen_ext_2  <= wr_d;
      cpu_enable <= (state_next == ST_RUN);
      if (err_set) err <= 1'b1;
      if (latch_lo) lo_word <= s_data;
      if (wr_i) begin
        addr_ext  <= {48'd0, idx, 2'b00};
        wdata_ext <= s_data;
      end
      if (wr_d) begin
        addr_ext_2  <= {47'd0, idx, 3'b000};
        wdata_ext_2 <= {s_data, lo_word};
      end
    end
  end

endmodule

// File: tb/tb_cpu_program_loader.sv
// Directed bench for cpu_program_loader: loads, range errors, run/halt gating,
// mid-load reset and a full-depth streaming load.
module tb_cpu_program_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic        s_valid;
  logic [31:0] s_data;
  logic        s_ready;
  logic        cpu_enable;
  logic [63:0] addr_ext;
  logic        wen_ext;
  logic        ren_ext;
  logic [31:0] wdata_ext;
  logic [63:0] addr_ext_2;
  logic        wen_ext_2;
  logic        ren_ext_2;
  logic [63:0] wdata_ext_2;
  logic        busy;
  logic        err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  cpu_program_loader #(.IMEM_WORDS(128), .DMEM_WORDS(128)) dut (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
    .cpu_enable(cpu_enable), .addr_ext(addr_ext), .wen_ext(wen_ext), .ren_ext(ren_ext),
    .wdata_ext(wdata_ext), .addr_ext_2(addr_ext_2), .wen_ext_2(wen_ext_2),
    .ren_ext_2(ren_ext_2), .wdata_ext_2(wdata_ext_2), .busy(busy), .err(err)
  );

  // Inputs change on the falling edge; outputs are observed there as well,
  // reflecting the transfer taken on the preceding rising edge.
  task automatic drive(input logic v, input logic [31:0] d);
    @(negedge clk);
    s_valid = v;
    s_data  = d;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b1; s_valid = 1'b0; s_data = '0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset();
    checks++; if (s_ready !== 1'b1) begin errors++; $display("FAIL reset_s_ready: got %b expected 1", s_ready); end
    checks++; if (cpu_enable !== 1'b0) begin errors++; $display("FAIL reset_cpu_enable: got %b expected 0", cpu_enable); end
    checks++; if ({wen_ext, wen_ext_2, ren_ext, ren_ext_2} !== 4'b0000) begin errors++; $display("FAIL reset_strobes: got %b expected 0000", {wen_ext, wen_ext_2, ren_ext, ren_ext_2}); end
    checks++; if (addr_ext !== 64'd0 || addr_ext_2 !== 64'd0) begin errors++; $display("FAIL reset_addr: got %h/%h expected 0/0", addr_ext, addr_ext_2); end
    checks++; if (wdata_ext !== 32'd0 || wdata_ext_2 !== 64'd0) begin errors++; $display("FAIL reset_wdata: got %h/%h expected 0/0", wdata_ext, wdata_ext_2); end
    checks++; if (busy !== 1'b0 || err !== 1'b0) begin errors++; $display("FAIL reset_busy_err: got %b%b expected 00", busy, err); end
  endtask

  task automatic test_load_i();
    apply_reset();
    drive(1'b1, 32'h0000_0002);
    drive(1'b1, 32'h0050_0093);
    checks++; if (busy !== 1'b1 || wen_ext !== 1'b0) begin errors++; $display("FAIL load_i_hdr: busy/wen got %b%b expected 10", busy, wen_ext); end
    drive(1'b1, 32'h00A0_0113);
    checks++; if (wen_ext !== 1'b1 || addr_ext !== 64'd0 || wdata_ext !== 32'h0050_0093) begin errors++; $display("FAIL load_i_w0: got wen=%b addr=%h data=%h expected 1/0/00500093", wen_ext, addr_ext, wdata_ext); end
    drive(1'b0, 32'h0);
    checks++; if (wen_ext !== 1'b1 || addr_ext !== 64'd4 || wdata_ext !== 32'h00A0_0113) begin errors++; $display("FAIL load_i_w1: got wen=%b addr=%h data=%h expected 1/4/00a00113", wen_ext, addr_ext, wdata_ext); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL load_i_done_busy: got %b expected 0", busy); end
    drive(1'b0, 32'h0);
    checks++; if (wen_ext !== 1'b0 || addr_ext !== 64'd4 || wdata_ext !== 32'h00A0_0113) begin errors++; $display("FAIL load_i_hold: got wen=%b addr=%h data=%h expected 0/4/00a00113", wen_ext, addr_ext, wdata_ext); end
  endtask

  task automatic test_load_d();
    apply_reset();
    drive(1'b1, 32'h4003_0001);
    drive(1'b1, 32'hDEAD_BEEF);
    drive(1'b1, 32'h0123_4567);
    checks++; if (wen_ext_2 !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL load_d_lo: wen2/busy got %b%b expected 01", wen_ext_2, busy); end
    drive(1'b0, 32'h0);
    checks++; if (wen_ext_2 !== 1'b1 || addr_ext_2 !== 64'h18 || wdata_ext_2 !== 64'h0123_4567_DEAD_BEEF) begin errors++; $display("FAIL load_d_write: got wen2=%b addr=%h data=%h expected 1/18/01234567deadbeef", wen_ext_2, addr_ext_2, wdata_ext_2); end
    checks++; if (wen_ext !== 1'b0) begin errors++; $display("FAIL load_d_no_imem: got %b expected 0", wen_ext); end
    drive(1'b0, 32'h0);
    checks++; if (wen_ext_2 !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL load_d_after: wen2/busy got %b%b expected 00", wen_ext_2, busy); end
  endtask

  task automatic test_range();
    int strobes;
    apply_reset();
    strobes = 0;
    drive(1'b1, 32'h007F_0002);
    drive(1'b1, 32'h1111_1111);
    checks++; if (err !== 1'b1 || busy !== 1'b1) begin errors++; $display("FAIL range_err: err/busy got %b%b expected 11", err, busy); end
    drive(1'b1, 32'h2222_2222);
    strobes += int'(wen_ext);
    drive(1'b0, 32'h0);
    strobes += int'(wen_ext);
    checks++; if (strobes != 0) begin errors++; $display("FAIL range_no_write: got %0d strobes expected 0", strobes); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL range_back_hdr: busy got %b expected 0", busy); end
    // start 126 + 2 lands exactly on the depth and must be accepted
    apply_reset();
    drive(1'b1, 32'h007E_0002);
    drive(1'b1, 32'hAAAA_0001);
    drive(1'b1, 32'hAAAA_0002);
    drive(1'b0, 32'h0);
    checks++; if (err !== 1'b0 || wen_ext !== 1'b1 || addr_ext !== 64'h1FC || wdata_ext !== 32'hAAAA_0002) begin errors++; $display("FAIL range_edge: got err=%b wen=%b addr=%h data=%h expected 0/1/1fc/aaaa0002", err, wen_ext, addr_ext, wdata_ext); end
    // zero-count header: no write, stays idle
    drive(1'b1, 32'h0000_0000);
    drive(1'b0, 32'h0);
    checks++; if (busy !== 1'b0 || wen_ext !== 1'b0) begin errors++; $display("FAIL zero_count: busy/wen got %b%b expected 00", busy, wen_ext); end
  endtask

  task automatic test_run_halt();
    apply_reset();
    drive(1'b1, 32'h8000_0000);
    checks++; if (cpu_enable !== 1'b0) begin errors++; $display("FAIL run_same_cycle: got %b expected 0", cpu_enable); end
    drive(1'b0, 32'h0);
    checks++; if (cpu_enable !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL run_enable: en/busy got %b%b expected 10", cpu_enable, busy); end
    drive(1'b1, 32'h0000_0002);
    drive(1'b0, 32'h0);
    checks++; if (err !== 1'b1 || cpu_enable !== 1'b1 || wen_ext !== 1'b0) begin errors++; $display("FAIL run_bad_hdr: err/en/wen got %b%b%b expected 110", err, cpu_enable, wen_ext); end
    drive(1'b1, 32'hC000_0000);
    drive(1'b0, 32'h0);
    checks++; if (cpu_enable !== 1'b0) begin errors++; $display("FAIL halt_disable: got %b expected 0", cpu_enable); end
    drive(1'b1, 32'hC000_0000);
    drive(1'b0, 32'h0);
    checks++; if (cpu_enable !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL halt_in_hdr: en/busy got %b%b expected 00", cpu_enable, busy); end
  endtask

  task automatic test_rst_mid_load();
    apply_reset();
    drive(1'b1, 32'h4000_0001);
    drive(1'b1, 32'h1111_1111);
    @(negedge clk);
    rst = 1'b1; s_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    checks++; if (busy !== 1'b0 || wen_ext_2 !== 1'b0) begin errors++; $display("FAIL rst_mid: busy/wen2 got %b%b expected 00", busy, wen_ext_2); end
    drive(1'b1, 32'h4000_0001);
    drive(1'b1, 32'hAAAA_AAAA);
    drive(1'b1, 32'hBBBB_BBBB);
    drive(1'b0, 32'h0);
    checks++; if (wen_ext_2 !== 1'b1 || addr_ext_2 !== 64'd0 || wdata_ext_2 !== 64'hBBBB_BBBB_AAAA_AAAA) begin errors++; $display("FAIL rst_mid_reload: got wen2=%b addr=%h data=%h expected 1/0/bbbbbbbbaaaaaaaa", wen_ext_2, addr_ext_2, wdata_ext_2); end
  endtask

  task automatic test_back_to_back();
    int strobes;
    int bad;
    apply_reset();
    strobes = 0;
    bad = 0;
    drive(1'b1, 32'h0000_0080);
    for (int i = 0; i < 129; i++) begin
      drive(i < 128, 32'h1000_0000 + 32'(i));
      if (i > 0) begin
        if (wen_ext === 1'b1) strobes++;
        if (wen_ext !== 1'b1 || addr_ext !== 64'(4 * (i - 1)) || wdata_ext !== 32'h1000_0000 + 32'(i - 1)) bad++;
      end
    end
    checks++; if (strobes != 128) begin errors++; $display("FAIL b2b_strobes: got %0d expected 128", strobes); end
    checks++; if (bad != 0) begin errors++; $display("FAIL b2b_sequence: got %0d bad cycles expected 0", bad); end
    drive(1'b0, 32'h0);
    checks++; if (wen_ext !== 1'b0 || busy !== 1'b0 || err !== 1'b0) begin errors++; $display("FAIL b2b_end: wen/busy/err got %b%b%b expected 000", wen_ext, busy, err); end
  endtask

  initial begin
    rst = 1'b1;
    s_valid = 1'b0;
    s_data = '0;
    test_reset();
    test_load_i();
    test_load_d();
    test_range();
    test_run_halt();
    test_rst_mid_load();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
